// File: rtl/rf_2r1w.sv
// RV32I integer register file: 32 x 32-bit, two combinational read ports, one write port, x0 hardwired to zero.
// Optional macro RF_WRITE_BYPASS_EN forwards the same-cycle write data to a matching read port.
module rf_2r1w #(
    parameter logic [31:0] RESET_VALUE = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic [4:0]  i_rs1_raddr,
    output logic [31:0] o_rs1_rdata,
    input  logic [4:0]  i_rs2_raddr,
    output logic [31:0] o_rs2_rdata,
    input  logic        i_rd_wen,
    input  logic [4:0]  i_rd_waddr,
    input  logic [31:0] i_rd_wdata
);
    localparam int NUM_RD = 2;

    logic [31:1][31:0]       r_regs;
    logic [31:0][31:0]       w_mem;
    logic [31:0]             w_we;
    logic [NUM_RD-1:0][4:0]  w_raddr;
    logic [NUM_RD-1:0][31:0] w_rdata;

    // One-hot write decode; bit 0 forced low so writes to x0 vanish.
    always_comb begin
        w_we = '0;
        if (i_rd_wen)
            w_we[i_rd_waddr] = 1'b1;
        w_we[0] = 1'b0;
    end

    always_ff @(posedge i_clk) begin
        for (int i = 1; i < 32; i++) begin
            if (i_rst)
                r_regs[i] <= RESET_VALUE;
            else if (w_we[i])
                r_regs[i] <= i_rd_wdata;
        end
    end

    // x0 has no storage: it is a constant zero slot in the read view.
    assign w_mem   = {r_regs, 32'h0000_0000};
    assign w_raddr = {i_rs2_raddr, i_rs1_raddr};

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
`ifdef RF_WRITE_BYPASS_EN
        logic w_byp;
        assign w_byp      = !i_rst && i_rd_wen && (i_rd_waddr != 5'd0) &&
                            (w_raddr[p] == i_rd_waddr);
        assign w_rdata[p] = w_byp ? i_rd_wdata : w_mem[w_raddr[p]];
`else
        assign w_rdata[p] = w_mem[w_raddr[p]];
`endif
    end

    assign o_rs1_rdata = w_rdata[0];
    assign o_rs2_rdata = w_rdata[1];

endmodule

// File: tb/tb_rf_2r1w.sv
// Randomised scoreboard bench for rf_2r1w: driver pushes expected read data, negedge monitor pops and compares.
module tb_rf_2r1w;
    localparam logic [31:0] RV = 32'h0000_0000;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic [4:0]  i_rs1_raddr = '0;
    logic [31:0] o_rs1_rdata;
    logic [4:0]  i_rs2_raddr = '0;
    logic [31:0] o_rs2_rdata;
    logic        i_rd_wen = 1'b0;
    logic [4:0]  i_rd_waddr = '0;
    logic [31:0] i_rd_wdata = '0;

    rf_2r1w #(.RESET_VALUE(RV)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_rs1_raddr (i_rs1_raddr),
        .o_rs1_rdata (o_rs1_rdata),
        .i_rs2_raddr (i_rs2_raddr),
        .o_rs2_rdata (o_rs2_rdata),
        .i_rd_wen    (i_rd_wen),
        .i_rd_waddr  (i_rd_waddr),
        .i_rd_wdata  (i_rd_wdata)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic        chk;
        logic [4:0]  a1;
        logic [4:0]  a2;
        logic [31:0] e1;
        logic [31:0] e2;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mdl [32];
    bit          known = 1'b0;
    int          checks = 0;
    int          errors = 0;

    // Architectural view: x0 is zero, otherwise the stored value, optionally overridden by a same-cycle write.
    function automatic logic [31:0] ref_rd(input logic [4:0] a, input logic rst, input logic wen,
                                           input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] v;
        v = (a == 5'd0) ? 32'h0 : mdl[a];
`ifdef RF_WRITE_BYPASS_EN
        if (!rst && wen && wa != 5'd0 && a == wa)
            v = wd;
`else
        if (rst && wen && wa == 5'd31 && wd == 32'h0) v = v;
`endif
        return v;
    endfunction

    task automatic cyc(input logic rst, input logic wen, input logic [4:0] wa, input logic [31:0] wd,
                       input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        @(posedge i_clk);
        #1;
        i_rst       = rst;
        i_rd_wen    = wen;
        i_rd_waddr  = wa;
        i_rd_wdata  = wd;
        i_rs1_raddr = a1;
        i_rs2_raddr = a2;
        e.chk = known;
        e.a1  = a1;
        e.a2  = a2;
        e.e1  = ref_rd(a1, rst, wen, wa, wd);
        e.e2  = ref_rd(a2, rst, wen, wa, wd);
        q.push_back(e);
        if (rst) begin
            for (int i = 1; i < 32; i++) mdl[i] = RV;
            known = 1'b1;
        end else if (wen && wa != 5'd0) begin
            mdl[wa] = wd;
        end
    endtask

    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            if (e.chk) begin
                checks += 2;
                if (o_rs1_rdata !== e.e1) begin
                    errors++;
                    $display("FAIL rs1 addr=%0d got=%h exp=%h", e.a1, o_rs1_rdata, e.e1);
                end
                if (o_rs2_rdata !== e.e2) begin
                    errors++;
                    $display("FAIL rs2 addr=%0d got=%h exp=%h", e.a2, o_rs2_rdata, e.e2);
                end
            end
        end
    end

    function automatic logic [4:0] ra();
        return 5'($urandom_range(0, 31));
    endfunction

    initial begin
        for (int i = 0; i < 32; i++) mdl[i] = 32'h0;

        // Reset held two cycles, then sweep every address on both ports.
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        cyc(1'b1, 1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // Simple write then readback; neighbour untouched.
        cyc(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd6);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd6, 5'd5);

        // x0 write is discarded, same-cycle and next-cycle.
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);

        // Same-cycle write/read of x7.
        cyc(1'b0, 1'b1, 5'd7, 32'h1234_5678, 5'd6, 5'd7);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);

        // Reset beats a concurrent write; reads in the reset cycle show old contents.
        cyc(1'b0, 1'b1, 5'd9, 32'h0000_0001, 5'd9, 5'd5);
        cyc(1'b1, 1'b1, 5'd9, 32'hA5A5_A5A5, 5'd9, 5'd9);
        cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd5);

        // Back-to-back writes to every register, junk idle cycles, then sweep.
        for (int i = 1; i < 32; i++)
            cyc(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, ra(), ra());
        for (int i = 0; i < 8; i++)
            cyc(1'b0, 1'b0, ra(), $urandom, ra(), ra());
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

        // Random traffic with occasional resets.
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 1)), ra(), $urandom, ra(), ra());
        for (int i = 0; i < 32; i++) cyc(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));

        repeat (3) @(negedge i_clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d exp=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rf_2r1w.md
Name: rf_2r1w

Overview:
- RV32I integer register file: 32 x 32-bit architectural registers.
- Two read ports, one write port.
- Sits directly upstream of the ALU and supplies its two operands (rs1 -> op1, rs2 -> op2 when not immediate).
- Writeback stage drives the write port.
- Single clock domain; x0 hardwired to zero.

Parameters:
- RESET_VALUE, 32'h0000_0000, value loaded into x1..x31 on reset.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_rst  input  1  synchronous active-high reset.
- i_rs1_raddr  input  5  read port 1 register index.
- o_rs1_rdata  output  32  read port 1 data.
- i_rs2_raddr  input  5  read port 2 register index.
- o_rs2_rdata  output  32  read port 2 data.
- i_rd_wen  input  1  write enable.
- i_rd_waddr  input  5  write register index.
- i_rd_wdata  input  32  write data.

Behaviour:
- Clocking/reset (already decided): one clock, i_clk; reset i_rst is synchronous and active-high.
- Storage: 31 physical 32-bit registers, x1..x31; no storage for x0.
- Reset:
  - When i_rst is high at a rising edge of i_clk, x1..x31 all load RESET_VALUE.
  - Any write presented in the same cycle is discarded.
  - Reset has priority over write.
  - i_rst held for N cycles has the same effect as 1 cycle.
- Write:
  - At a rising edge with i_rst low and i_rd_wen high, register[i_rd_waddr] <= i_rd_wdata.
  - Write takes effect for reads from the next cycle (1-cycle write latency).
  - i_rd_waddr == 0: write silently discarded, no state change.
  - i_rd_wen low: no state change, regardless of address/data.
- Read:
  - Combinational (asynchronous) in the base build.
  - o_rsN_rdata = register[i_rsN_raddr] as of the last rising edge.
  - Read address 0 always returns 32'h0000_0000, independent of any write or reset value.
  - Both ports are independent and may address the same register; both return identical data.
- Read outputs after reset:
  - x1..x31 read RESET_VALUE; x0 reads 0.
  - Before the first reset edge, contents are undefined; the bench does not check them.
- Same-cycle write/read of the same index (base build): read returns the OLD value; the new value is visible the following cycle.
- Reset mid-operation:
  - A write pending in the cycle reset asserts is lost.
  - Reads in that cycle still show pre-reset contents (combinational); RESET_VALUE appears in the following cycle.
- No X propagation: all 5-bit addresses are valid; no out-of-range case exists.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined: write-to-read bypass on each read port.
  - Condition: i_rst low, i_rd_wen high, i_rd_waddr != 0, and i_rsN_raddr == i_rd_waddr.
  - Effect: o_rsN_rdata = i_rd_wdata in the same cycle.
  - Removes the writeback-to-decode hazard.
  - Address 0 never bypasses.
  - Bypass is suppressed while i_rst is high.
- Not defined: no bypass; same-cycle read returns the old value as described in Behaviour.
- Storage update timing is identical in both builds.

Test Plan:
1. Reset with RESET_VALUE=0: assert i_rst 2 cycles, deassert -> all 32 addresses read 32'h0 on both ports.
2. Write x5=32'hDEAD_BEEF, next cycle read rs1=5, rs2=5 -> both ports 32'hDEAD_BEEF; rs1=6 still 32'h0.
3. Write x0=32'hFFFF_FFFF, next cycle read rs1=0 -> 32'h0. With RF_WRITE_BYPASS_EN, a same-cycle read of 0 also returns 32'h0.
4. Write x7=32'h1234_5678 while rs2_raddr=7 in the same cycle:
   - Base build: 0 (prior value) that cycle, 32'h1234_5678 the next.
   - With RF_WRITE_BYPASS_EN: 32'h1234_5678 that cycle.
5. i_rst high and i_rd_wen high (x9=32'hA5A5_A5A5) in the same cycle, previously x9=32'h1 -> after the edge x9 reads RESET_VALUE, not 32'hA5A5_A5A5.
6. Back-to-back writes x1..x31 with value = index*32'h0101_0101, then sweep reads on both ports -> every register returns its written value; x0 returns 0; i_rd_wen=0 cycles with junk data leave contents unchanged.
